// File: rtl/wptr_full_gen.sv
// wptr_full_gen: write-side pointer and full-flag generator for an async FIFO.
// Keeps a binary write pointer, publishes its Gray form to the read domain,
// and derives full, fill level and overflow from the synchronized read pointer.
// Optional feature: define ALMOST_FULL_EN to add the registered almost_full
// output (threshold AF_LEVEL entries).
module wptr_full_gen #(
  parameter int ADDR_BITS = 3,
  parameter int AF_LEVEL  = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_en,
  input  logic [ADDR_BITS:0]   rd_ptr_gray_sync,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic                 w_mem_en,
  output logic [ADDR_BITS:0]   wr_ptr_gray,
  output logic                 full,
  output logic [ADDR_BITS:0]   wr_count,
  output logic                 w_ovf
`ifdef ALMOST_FULL_EN
  ,
  output logic                 almost_full
`endif
);

  localparam int PW = ADDR_BITS + 1;
  // Flipping the top two Gray bits of the read pointer gives the Gray code of
  // (read pointer + depth), i.e. where the write pointer sits when full.
  localparam logic [PW-1:0] TOP2_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic          full_q, full_d;
  logic [PW-1:0] wr_count_q, wr_count_d;
  logic          w_ovf_q, w_ovf_d;
  logic [PW-1:0] rd_bin_sync;
  logic [PW-1:0] fill_next;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of bits i..MSB.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_rd_bin
      assign rd_bin_sync[gi] = ^rd_ptr_gray_sync[PW-1:gi];
    end
  endgenerate

  // Next-state logic: advance on an accepted write, compare against the read side.
  always_comb begin
    w_mem_en      = w_en & ~full_q;
    wr_bin_d      = wr_bin_q + {{ADDR_BITS{1'b0}}, w_mem_en};
    wr_ptr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    full_d        = (wr_ptr_gray_d == (rd_ptr_gray_sync ^ TOP2_MASK));
    fill_next     = wr_bin_d - rd_bin_sync;
    wr_count_d    = fill_next;
    w_ovf_d       = w_en & full_q;
  end

  // Pointer and status registers with synchronous active-low reset.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      wr_bin_q      <= '0;
      wr_ptr_gray_q <= '0;
      full_q        <= 1'b0;
      wr_count_q    <= '0;
      w_ovf_q       <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      full_q        <= full_d;
      wr_count_q    <= wr_count_d;
      w_ovf_q       <= w_ovf_d;
    end
  end

  assign w_addr      = wr_bin_q[ADDR_BITS-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign wr_count    = wr_count_q;
  assign w_ovf       = w_ovf_q;

`ifdef ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  logic almost_full_q, almost_full_d;

  // Almost-full threshold on the post-edge fill level.
  always_comb begin
    almost_full_d = (fill_next >= AF_THR);
  end

  // Almost-full register, cleared by reset like the other flags.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// tb_wptr_full_gen: randomized + directed bench for wptr_full_gen (ADDR_BITS = 3).
// Reference model tracks total writes accepted and total reads seen as plain
// integers; every expected output is derived from their difference.
module tb_wptr_full_gen;

  localparam int AB    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_en;
  logic [AB:0]   rd_ptr_gray_sync;
  logic [AB-1:0] w_addr;
  logic          w_mem_en;
  logic [AB:0]   wr_ptr_gray;
  logic          full;
  logic [AB:0]   wr_count;
  logic          w_ovf;
`ifdef ALMOST_FULL_EN
  logic          almost_full;
`endif

  always #5 w_clk = ~w_clk;

  wptr_full_gen #(.ADDR_BITS(AB), .AF_LEVEL(AFL)) dut (
    .w_clk            (w_clk),
    .w_rst            (w_rst),
    .w_en             (w_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .w_addr           (w_addr),
    .w_mem_en         (w_mem_en),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .wr_count         (wr_count),
    .w_ovf            (w_ovf)
`ifdef ALMOST_FULL_EN
    ,
    .almost_full      (almost_full)
`endif
  );

  // Reference state: cumulative counts of writes accepted and reads observed.
  int wcnt    = 0;
  int rcnt    = 0;
  bit full_m  = 1'b0;
  bit started = 1'b0;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    check_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [AB:0] to_gray(input int v);
    logic [AB:0] b;
    b = (AB+1)'(v % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  // One clock transaction: drive inputs, check the combinational strobe,
  // clock, then compare every registered output with the model.
  task automatic step(input bit rst_n, input bit we, input bit radv);
    bit acc;
    bit ovf_exp;
    int lvl;
    w_rst = rst_n;
    w_en  = we;
    if (!rst_n) rcnt = 0;
    else if (radv && rcnt < wcnt) rcnt++;
    rd_ptr_gray_sync = to_gray(rcnt);
    #1;
    if (started) check("w_mem_en", int'(w_mem_en), int'(we && !full_m));
    acc     = we && !full_m;
    ovf_exp = rst_n && we && full_m;
    @(posedge w_clk);
    #1;
    started = 1'b1;
    if (!rst_n) begin
      wcnt   = 0;
      full_m = 1'b0;
      lvl    = 0;
    end else begin
      wcnt   = wcnt + int'(acc);
      lvl    = wcnt - rcnt;
      full_m = (lvl == DEPTH);
    end
    check("wr_ptr_gray", int'(wr_ptr_gray), int'(to_gray(wcnt)));
    check("full",        int'(full),        int'(full_m));
    check("wr_count",    int'(wr_count),    rst_n ? lvl : 0);
    check("w_ovf",       int'(w_ovf),       int'(ovf_exp));
    check("w_addr",      int'(w_addr),      wcnt % DEPTH);
`ifdef ALMOST_FULL_EN
    check("almost_full", int'(almost_full), int'(rst_n && lvl >= AFL));
`endif
    $display("t=%0t rst_n=%0b we=%0b rd_g=%h wr_g=%h cnt=%0d full=%0b ovf=%0b",
             $time, rst_n, we, rd_ptr_gray_sync, wr_ptr_gray, wr_count, full, w_ovf);
  endtask

  initial begin
    w_rst = 1'b0;
    w_en  = 1'b0;
    rd_ptr_gray_sync = '0;

    // Reset held for two edges while the producer is requesting writes.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Fill all eight entries with the read pointer parked at zero.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_gray", int'(wr_ptr_gray), 12);

    // Overflow attempt, then idle: w_ovf pulses exactly once.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Release: read pointer advances by one with no write.
    step(1'b1, 1'b0, 1'b1);
    check("release_cnt", int'(wr_count), 7);

    // Simultaneous write and read advance keeps the level.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);

    // Wrap: restart, fill, drain to binary 8, refill to wrap to zero.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0);
    check("wrap_gray", int'(wr_ptr_gray), 0);
    check("wrap_full", int'(full), 1);

    // Randomized traffic with occasional mid-burst resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 5));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/wptr_full_gen.md
WPTR_FULL_GEN -- requirements
Module: wptr_full_gen

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 3, meaning FIFO address width (depth = 2^ADDR_BITS; pointers are ADDR_BITS+1 bits).
REQ-002 SHALL have parameter AF_LEVEL, default 6, meaning the almost-full threshold in entries (used only with ALMOST_FULL_EN).
REQ-003 SHALL have port w_clk  input  1  write-domain clock; the only clock; all state updates on its rising edge.
REQ-004 SHALL have port w_rst  input  1  reset: synchronous, active-low, sampled on rising w_clk.
REQ-005 SHALL have port w_en  input  1  write request from the producer.
REQ-006 SHALL have port rd_ptr_gray_sync  input  ADDR_BITS+1  Gray read pointer already synchronized into w_clk.
REQ-007 SHALL have port w_addr  output  ADDR_BITS  RAM write address = low ADDR_BITS of the binary write pointer.
REQ-008 SHALL have port w_mem_en  output  1  RAM write strobe = w_en AND NOT full (combinational).
REQ-009 SHALL have port wr_ptr_gray  output  ADDR_BITS+1  registered Gray write pointer for the write-to-read synchronizer.
REQ-010 SHALL have port full  output  1  registered FIFO-full flag.
REQ-011 SHALL have port wr_count  output  ADDR_BITS+1  registered fill level seen from the write side (0..2^ADDR_BITS).
REQ-012 SHALL have port w_ovf  output  1  registered one-cycle pulse for a write attempted while full.
REQ-013 SHALL have port almost_full  output  1  registered flag, present only when ALMOST_FULL_EN is defined.

Function
REQ-014 SHALL hold a binary write pointer wr_bin (ADDR_BITS+1 bits); wr_bin_next = wr_bin + w_mem_en, modulo 2^(ADDR_BITS+1).
REQ-015 SHALL register wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1) each edge, so wr_ptr_gray always equals Gray(wr_bin).
REQ-016 SHALL register full <= (Gray(wr_bin_next) == {~rd_ptr_gray_sync[top two bits], rd_ptr_gray_sync[remaining bits]}); full asserts on the same edge that accepts the write filling the last entry (zero-cycle latency).
REQ-017 SHALL convert rd_ptr_gray_sync to binary rd_bin_sync combinationally (bit i = XOR of bits i..MSB).
REQ-018 SHALL register wr_count <= (wr_bin_next - rd_bin_sync) modulo 2^(ADDR_BITS+1).
REQ-019 SHALL ignore w_en while full is 1: pointers hold, w_mem_en = 0, and w_ovf = 1 on the following cycle only.
REQ-020 SHALL deassert full on the first edge where rd_ptr_gray_sync shows read progress, even if the same edge carries no write.
REQ-021 SHALL wrap pointers silently from all-ones to zero; the MSB toggle distinguishes full from empty.
REQ-022 SHALL treat simultaneous write and read-pointer advance by evaluating REQ-016/018 with both new values; full stays 0 and wr_count stays unchanged.

Reset
REQ-023 SHALL, on any rising w_clk with w_rst = 0, set wr_bin, wr_ptr_gray, w_addr, full, wr_count, w_ovf and almost_full to 0, overriding w_en, including mid-burst.
REQ-024 SHALL drive w_mem_en = w_en while in reset, since full = 0; the consumer gates RAM writes with reset.

Configuration
REQ-025 SHALL, with macro ALMOST_FULL_EN defined, provide almost_full registered as (wr_bin_next - rd_bin_sync) >= AF_LEVEL.
REQ-026 SHALL, without ALMOST_FULL_EN, omit the almost_full port and its logic entirely; all other behaviour is identical.

Verification (ADDR_BITS = 3)
REQ-027 SHALL cover reset: w_rst = 0 for 2 edges during w_en = 1 -> wr_ptr_gray = 0000, full = 0, wr_count = 0, w_ovf = 0.
REQ-028 SHALL cover fill: rd_ptr_gray_sync = 0000 with 8 consecutive w_en cycles -> w_addr 0..7, full = 1 and wr_ptr_gray = 1100 after the 8th edge, wr_count = 8.
REQ-029 SHALL cover overflow: w_en = 1 while full -> w_mem_en = 0, wr_ptr_gray stays 1100, and w_ovf = 1 for exactly one cycle.
REQ-030 SHALL cover release: while full, rd_ptr_gray_sync 0000 -> 0001 -> full = 0 and wr_count = 7 at the next edge.
REQ-031 SHALL cover wrap: rd_ptr_gray_sync = 1100 (binary 8) followed by 8 writes -> wr_ptr_gray = 0000 and full = 1.
REQ-032 SHALL cover almost-full: with ALMOST_FULL_EN and AF_LEVEL = 6, rd = 0 and 6 writes -> almost_full = 1 after the 6th edge and 0 after 5 writes.
